// File: rtl/at_tree_multi.sv
// at_tree_multi: per-class allocation bitmaps with first-zero search, forwarded RMW updates and row summaries.
// Defining AT_TREE_ALLOC_MARK_EN makes a successful search claim the slot it found.
module at_tree_multi #(
    parameter int NUM_CLASSES   = 4,
    parameter int ROW_WIDTH     = 64,
    parameter int ROW_IDX_WIDTH = 6,
    parameter int ID_WIDTH      = 8,
    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int BW = $clog2(ROW_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          search_valid,
    output logic                          search_ready,
    input  logic [ID_WIDTH-1:0]           search_id,
    input  logic [ROW_IDX_WIDTH-1:0]      search_row,
    input  logic [CW-1:0]                 search_class,
    output logic                          result_valid,
    output logic [ID_WIDTH-1:0]           result_id,
    output logic [CW-1:0]                 result_class,
    output logic                          result_found,
    output logic [ROW_IDX_WIDTH+BW-1:0]   result_index,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic [ROW_IDX_WIDTH-1:0]      upd_row,
    input  logic [BW-1:0]                 upd_col,
    input  logic [NUM_CLASSES-1:0]        upd_bits,
    output logic                          summary_valid,
    output logic [ROW_IDX_WIDTH-1:0]      summary_row,
    output logic [NUM_CLASSES-1:0]        summary_bits
);
    localparam int RW = ROW_IDX_WIDTH;
    typedef logic [NUM_CLASSES-1:0][ROW_WIDTH-1:0] row_t;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef struct packed {
        logic valid; logic [ID_WIDTH-1:0] id; logic [CW-1:0] cls; logic [RW-1:0] row; logic [ROW_WIDTH-1:0] data;
    } s1_t;
    typedef struct packed {
        logic valid; logic [ID_WIDTH-1:0] id; logic [CW-1:0] cls; logic found; logic [RW+BW-1:0] index;
    } res_t;
    typedef struct packed {
        logic valid; logic [RW-1:0] row; logic [BW-1:0] col; logic [NUM_CLASSES-1:0] bits;
        logic [NUM_CLASSES-1:0] mask; row_t data;
    } u1_t;
    typedef struct packed { logic valid; logic [RW-1:0] row; row_t data; } u2_t;
    typedef struct packed { logic valid; logic [RW-1:0] row; logic [NUM_CLASSES-1:0] bits; } sum_t;

    row_t mem_q [1<<RW];
    state_t state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    s1_t s1_q, s1_d;
    res_t res_q, res_d;
    u1_t u1_q, u1_d;
    u2_t u2_q, u2_d;
    sum_t sum_q, sum_d;
    logic run, init_wr, claim_fire, found;
    logic [BW-1:0] pos;
    logic [RW-1:0] u0_row;
    row_t u1_new, u0_rd, s_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (&cnt_q) ? ST_RUN : ST_INIT;
        end
    end

    always_comb begin
        run     = state_q == ST_RUN;
        init_wr = state_q == ST_INIT;
    end

`ifdef AT_TREE_ALLOC_MARK_EN
    // Claim flags track the injected write through U1/U2 so searches stay blocked until it lands.
    logic [1:0] claim_q, claim_d;
    always_comb begin
        claim_fire   = res_q.valid && res_q.found;
        claim_d      = {claim_q[0], claim_fire};
        search_ready = run && !s1_q.valid && !res_q.valid && !(|claim_q);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) claim_q <= '0;
        else claim_q <= claim_d;
    end
`else
    always_comb begin
        claim_fire   = 1'b0;
        search_ready = run;
    end
`endif

    always_comb begin
        u1_new = u1_q.data;
        for (int k = 0; k < NUM_CLASSES; k++)
            if (u1_q.mask[k]) u1_new[k][u1_q.col] = u1_q.bits[k];
    end

    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = ROW_WIDTH-1; i >= 0; i--)
            if (!s1_q.data[i]) begin
                found = 1'b1;
                pos   = i[BW-1:0];
            end
    end

    always_comb begin
        upd_ready = run && !claim_fire;
        u0_row    = claim_fire ? res_q.index[BW +: RW] : upd_row;
        // Youngest in-flight write wins: U1 result first, then U2, then the array.
        u0_rd = (u1_q.valid && u1_q.row == u0_row) ? u1_new :
                (u2_q.valid && u2_q.row == u0_row) ? u2_q.data : mem_q[u0_row];
        s_rd  = (u1_q.valid && u1_q.row == search_row) ? u1_new :
                (u2_q.valid && u2_q.row == search_row) ? u2_q.data : mem_q[search_row];
        s1_d  = '{valid: search_valid && search_ready, id: search_id, cls: search_class,
                  row: search_row, data: s_rd[search_class]};
        res_d = '{valid: s1_q.valid, id: s1_q.id, cls: s1_q.cls, found: s1_q.valid && found,
                  index: found ? {s1_q.row, pos} : '0};
        u1_d  = '{valid: (upd_valid && upd_ready) || claim_fire, row: u0_row,
                  col: claim_fire ? res_q.index[BW-1:0] : upd_col,
                  bits: claim_fire ? '1 : upd_bits,
                  mask: claim_fire ? NUM_CLASSES'(1) << res_q.cls : '1, data: u0_rd};
        u2_d  = '{valid: u1_q.valid, row: u1_q.row, data: u1_new};
        sum_d = '{valid: u1_q.valid, row: u1_q.row, bits: '0};
        for (int k = 0; k < NUM_CLASSES; k++) sum_d.bits[k] = &u1_new[k];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q  <= '0;
            res_q <= '0;
            u1_q  <= '0;
            u2_q  <= '0;
            sum_q <= '0;
        end else begin
            s1_q  <= s1_d;
            res_q <= res_d;
            u1_q  <= u1_d;
            u2_q  <= u2_d;
            sum_q <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        if (init_wr) mem_q[cnt_q] <= '0;
        else if (u2_q.valid) mem_q[u2_q.row] <= u2_q.data;
    end

    assign result_valid  = res_q.valid;
    assign result_id     = res_q.id;
    assign result_class  = res_q.cls;
    assign result_found  = res_q.found;
    assign result_index  = res_q.index;
    assign summary_valid = sum_q.valid;
    assign summary_row   = sum_q.row;
    assign summary_bits  = sum_q.bits;
endmodule

// File: tb/tb_at_tree_multi.sv
// tb_at_tree_multi: directed-vector bench for at_tree_multi with hand-computed expectations.
module tb_at_tree_multi;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic search_valid, search_ready, result_valid, result_found;
    logic [7:0] search_id, result_id;
    logic [5:0] search_row, upd_row, upd_col, summary_row;
    logic [1:0] search_class, result_class;
    logic [11:0] result_index;
    logic upd_valid, upd_ready, summary_valid;
    logic [3:0] upd_bits, summary_bits;
    int n_vec = 0;
    int n_err = 0;

    at_tree_multi dut (
        .clk(clk), .rst_n(rst_n),
        .search_valid(search_valid), .search_ready(search_ready), .search_id(search_id),
        .search_row(search_row), .search_class(search_class),
        .result_valid(result_valid), .result_id(result_id), .result_class(result_class),
        .result_found(result_found), .result_index(result_index),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_row(upd_row), .upd_col(upd_col),
        .upd_bits(upd_bits),
        .summary_valid(summary_valid), .summary_row(summary_row), .summary_bits(summary_bits)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle;
        search_valid = 1'b0;
        upd_valid    = 1'b0;
    endtask

    task automatic srch(input logic [7:0] id, input logic [5:0] row, input logic [1:0] cls);
        search_valid = 1'b1;
        search_id    = id;
        search_row   = row;
        search_class = cls;
    endtask

    task automatic upd(input logic [5:0] row, input logic [5:0] col, input logic [3:0] bits);
        upd_valid = 1'b1;
        upd_row   = row;
        upd_col   = col;
        upd_bits  = bits;
    endtask

    task automatic chk_res(input string tag, input logic [7:0] id, input logic [1:0] cls,
                           input logic fnd, input logic [11:0] idx);
        chk({tag, "_valid"}, 32'(result_valid), 1);
        chk({tag, "_id"}, 32'(result_id), 32'(id));
        chk({tag, "_class"}, 32'(result_class), 32'(cls));
        chk({tag, "_found"}, 32'(result_found), 32'(fnd));
        chk({tag, "_index"}, 32'(result_index), 32'(idx));
    endtask

    task automatic chk_sum(input string tag, input logic [5:0] row, input logic [3:0] bits);
        chk({tag, "_valid"}, 32'(summary_valid), 1);
        chk({tag, "_row"}, 32'(summary_row), 32'(row));
        chk({tag, "_bits"}, 32'(summary_bits), 32'(bits));
    endtask

    task automatic init_phase(input string tag);
        for (int i = 0; i < 64; i++) begin
            chk({tag, "_ready_low"}, 32'({search_ready, upd_ready}), 0);
            chk({tag, "_quiet"}, 32'({result_valid, summary_valid}), 0);
            tick;
        end
        chk({tag, "_ready_high"}, 32'({search_ready, upd_ready}), 3);
    endtask

    initial begin
        idle;
        search_id = '0; search_row = '0; search_class = '0;
        upd_row = '0; upd_col = '0; upd_bits = '0;
        repeat (3) tick;
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_summary_valid", 32'(summary_valid), 0);
        chk("rst_ready", 32'({search_ready, upd_ready}), 0);
        rst_n = 1'b1;
        init_phase("init");
`ifdef AT_TREE_ALLOC_MARK_EN
        srch(8'h21, 6'd2, 2'd3);
        tick;
        idle;
        chk("claim_sready_t1", 32'(search_ready), 0);
        tick;
        chk_res("claim_first", 8'h21, 2'd3, 1'b1, 12'd128);
        chk("claim_uready_t2", 32'(upd_ready), 0);
        chk("claim_sready_t2", 32'(search_ready), 0);
        tick;
        chk("claim_sready_t3", 32'(search_ready), 0);
        chk("claim_uready_t3", 32'(upd_ready), 1);
        chk("claim_nosum_t3", 32'(summary_valid), 0);
        tick;
        chk("claim_sready_t4", 32'(search_ready), 0);
        chk_sum("claim_sum", 6'd2, 4'b0000);
        tick;
        chk("claim_sready_t5", 32'(search_ready), 1);
        srch(8'h22, 6'd2, 2'd3);
        tick;
        idle;
        tick;
        chk_res("claim_second", 8'h22, 2'd3, 1'b1, 12'd129);
        tick;
`else
        srch(8'h11, 6'd5, 2'd0);
        tick;
        idle;
        chk("lat_t1", 32'(result_valid), 0);
        tick;
        chk_res("row5_empty", 8'h11, 2'd0, 1'b1, 12'd320);
        tick;
        chk("res_one_cycle", 32'(result_valid), 0);
        for (int c = 0; c < 64; c++) begin
            upd(6'd5, c[5:0], 4'b0001);
            tick;
        end
        idle;
        srch(8'h12, 6'd5, 2'd0);
        chk_sum("row5_col62_sum", 6'd5, 4'b0000);
        tick;
        idle;
        chk_sum("row5_full_sum", 6'd5, 4'b0001);
        tick;
        chk_res("row5_full", 8'h12, 2'd0, 1'b0, 12'd0);
        chk("row5_sum_done", 32'(summary_valid), 0);
        srch(8'h13, 6'd5, 2'd1);
        tick;
        idle;
        tick;
        chk_res("row5_cls1", 8'h13, 2'd1, 1'b1, 12'd320);
        for (int c = 0; c < 10; c++) begin
            upd(6'd3, c[5:0], 4'b1111);
            tick;
        end
        upd(6'd3, 6'd10, 4'b1111);
        tick;
        upd(6'd3, 6'd11, 4'b0010);
        tick;
        idle;
        chk_sum("row3_col10_sum", 6'd3, 4'b0000);
        tick;
        chk_sum("row3_col11_sum", 6'd3, 4'b0000);
        srch(8'h30, 6'd3, 2'd0);
        tick;
        srch(8'h31, 6'd3, 2'd1);
        tick;
        srch(8'h32, 6'd3, 2'd2);
        chk_res("row3_c0", 8'h30, 2'd0, 1'b1, 12'd203);
        tick;
        srch(8'h33, 6'd3, 2'd3);
        chk_res("row3_c1", 8'h31, 2'd1, 1'b1, 12'd204);
        tick;
        idle;
        chk_res("row3_c2", 8'h32, 2'd2, 1'b1, 12'd203);
        tick;
        chk_res("row3_c3", 8'h33, 2'd3, 1'b1, 12'd203);
        tick;
        srch(8'h40, 6'd7, 2'd0);
        upd(6'd7, 6'd0, 4'b0001);
        tick;
        idle;
        srch(8'h41, 6'd7, 2'd0);
        tick;
        idle;
        chk_res("row7_pre", 8'h40, 2'd0, 1'b1, 12'd448);
        tick;
        chk_res("row7_post", 8'h41, 2'd0, 1'b1, 12'd449);
        tick;
        srch(8'h50, 6'd7, 2'd1);
        upd(6'd9, 6'd0, 4'b1111);
        tick;
        idle;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        init_phase("reinit");
        srch(8'h60, 6'd5, 2'd0);
        tick;
        idle;
        tick;
        chk_res("row5_cleared", 8'h60, 2'd0, 1'b1, 12'd320);
        tick;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/at_tree_multi.md
Name: at_tree_multi

Overview:
- Parametrised successor of the 4-class AND-tree bitmap stage of the MMU allocator.
- Holds NUM_CLASSES bitmaps, one per size class. Each bitmap has 2^ROW_IDX_WIDTH rows of ROW_WIDTH bits; a 1 bit means the slot is used.
- Serves first-zero searches from the FDT with a valid/ready handshake.
- Applies read-modify-write updates from the OR tree with full hazard forwarding.
- Emits per-row AND-reduced summaries back to the FDT.
- Adds a self-clearing init sequencer and an optional claim-on-alloc mode.

Parameters:
NUM_CLASSES, 4, number of size classes / bitmaps (>=1)
ROW_WIDTH, 64, bits per row (power of 2, >=2)
ROW_IDX_WIDTH, 6, row address width; depth = 2^ROW_IDX_WIDTH
ID_WIDTH, 8, request id width
(Derived: CW = max(1,$clog2(NUM_CLASSES)); BW = $clog2(ROW_WIDTH))

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
search_valid  in  1  search request
search_ready  out  1  search accepted when valid&ready
search_id  in  ID_WIDTH  request id
search_row  in  ROW_IDX_WIDTH  row to scan
search_class  in  CW  size class
result_valid  out  1  one-cycle result strobe
result_id  out  ID_WIDTH  echoed id
result_class  out  CW  echoed class
result_found  out  1  a zero bit existed
result_index  out  ROW_IDX_WIDTH+BW  row*ROW_WIDTH + bit position
upd_valid  in  1  update request
upd_ready  out  1  update accepted when valid&ready
upd_row  in  ROW_IDX_WIDTH  row
upd_col  in  BW  column
upd_bits  in  NUM_CLASSES  new bit value per class at (row,col)
summary_valid  out  1  summary strobe
summary_row  out  ROW_IDX_WIDTH  updated row
summary_bits  out  NUM_CLASSES  bit k = AND of class-k row after the write

Behaviour:
- Reset (rst_n low at posedge):
  - All outputs 0, all pipelines flushed, in-flight results/summaries discarded, FSM enters INIT with row counter 0.
  - Reset mid-operation gives no partial outputs.
- FSM INIT:
  - Writes all-zero to row counter in every class, one row per cycle.
  - search_ready=0 and upd_ready=0 throughout.
  - After the row 2^ROW_IDX_WIDTH-1 write, moves to RUN. Ready is first high in the cycle after the final clear.
  - No summaries are emitted during INIT.
- FSM RUN:
  - upd_ready=1, except as stated under the optional feature.
  - search_ready=1, except as stated under the optional feature.
- Search pipeline (latency 2, throughput 1/cycle):
  - Accepted at cycle t; result_* valid for exactly one cycle at t+2.
  - Scans the class row for the lowest-index 0 bit.
  - found=0 (all ones): result_found=0, result_index=0.
- Update pipeline (throughput 1/cycle):
  - Accepted at t: read row at t, modify at t+1, write plus registered summary at t+2.
  - Only column upd_col is changed in each class; all other bits are preserved.
- Coherency:
  - A search or update accepted at cycle t observes every update accepted at cycle < t. This holds even when the write has not yet reached the array; forward from the U1/U2 stages, youngest first.
  - A search and an update accepted in the same cycle: the search sees pre-update data.
  - Back-to-back updates to the same row and column: the last one wins.
- result_index arithmetic is concatenation {row, pos}; no overflow is possible.

Optional Feature:
- Macro AT_TREE_ALLOC_MARK_EN.
- When defined, a successful search claims its slot:
  - In the result cycle (t+2, found=1), an internal update enters the update pipeline.
  - It sets bit pos of row search_row for result_class to 1 only; other classes keep their values.
  - It produces a summary at t+4 like any update.
  - upd_ready=0 in the claim-injection cycle.
  - search_ready=0 from acceptance until the claim write completes, so the next accept is at t+5 at earliest. If found=0 there is no claim and the next accept is at t+3.
- When undefined, the array is never written by searches and search_ready is independent of searches.

Test Plan:
- Release reset, depth 64 -> ready low for 64 cycles, high at cycle 65; then a search of row 5, class 0 -> result at +2 with found=1, index 320.
- Updates (row 5, col 0..63, bits 4'b0001) one per cycle, then search row 5 class 0 in the cycle after the last update -> found=0, index 0; final summary row 5 bits 4'b0001.
- Update (row 3, col 10, 4'b1111), then in the next cycle update (row 3, col 11, 4'b0010) -> second summary keeps col 10 set; class-1 row 3 bits 10 and 11 = 1, class-0 bit 11 = 0.
- Search plus update to row 7 col 0 class 0 in the same cycle -> result index 448 (pre-update); a search in the following cycle -> index 449.
- Assert rst_n for 1 cycle while a result and a summary are in flight -> neither emitted; INIT restarts.
- With AT_TREE_ALLOC_MARK_EN, two searches of row 2 class 3 -> indices 128 then 129; second accept no earlier than 5 cycles after the first; upd_ready low in the claim cycle.
